// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer controller.
//   UART_DATA_W   : width of a received character
//   IDLE_BITS_DEF : default bit periods of line idle before Idle_Timeout
//   en_state_e    : receiver-enable FSM encoding
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int IDLE_BITS_DEF = 20;

    typedef enum logic {
        ST_EN   = 1'b0,
        ST_HOLD = 1'b1
    } en_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO holding received bytes.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i     : write request and byte (dropped if full without a read)
//   rd_en_i                : read request (ignored while empty)
//   rd_data_o, rd_valid_o  : registered read byte, one-cycle valid pulse
//   level_o, full_o, empty_o : registered occupancy flags
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic                   rd_en_i,
    output logic [UART_DATA_W-1:0] rd_data_o,
    output logic                   rd_valid_o,
    output logic [AW:0]            level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [AW:0]            level_q, level_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic [UART_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                   rd_valid_q;
    logic                   rd_acc, wr_acc;

    // A write into a full FIFO is still legal when a read frees a slot in
    // the same cycle; there is no read-through when empty.
    assign rd_acc = rd_en_i && !empty_q;
    assign wr_acc = wr_en_i && (!full_q || rd_acc);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d    = rptr_q + AW'(1);
            rd_data_d = mem_q[rptr_q];
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == FULL_LVL);
        empty_d = (level_d == '0);
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign level_o    = level_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer controller: gates the receiver enable, buffers each
// completed byte in a FIFO and serves it to a consumer via Rd_Req/Rd_Valid.
// Ports:
//   CLK, RSTn                  : clock, asynchronous active-low reset
//   BPS_CLK                    : one-cycle bit-period tick
//   Count_Sig                  : receiver busy with a frame
//   RX_Done_Sig, RX_Data       : completed byte strobe and data
//   RX_En_Sig                  : receiver enable
//   Rd_Req, Rd_Data, Rd_Valid  : consumer read handshake (1-cycle latency)
//   Empty, Full, Level         : FIFO status
//   Overflow, Clr_Ovf          : sticky drop flag and its clear
//   Idle_Timeout               : one-cycle pulse after line idle with data held
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int IDLE_BITS = IDLE_BITS_DEF
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   BPS_CLK,
    input  logic                   Count_Sig,
    input  logic                   RX_Done_Sig,
    input  logic [UART_DATA_W-1:0] RX_Data,
    output logic                   RX_En_Sig,
    input  logic                   Rd_Req,
    output logic [UART_DATA_W-1:0] Rd_Data,
    output logic                   Rd_Valid,
    output logic                   Empty,
    output logic                   Full,
    output logic [AW:0]            Level,
    output logic                   Overflow,
    input  logic                   Clr_Ovf,
    output logic                   Idle_Timeout
);

    localparam int CW = $clog2(IDLE_BITS + 1);

    en_state_e     state_q, state_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          fired_q, fired_d;
    logic          idle_to_q, idle_to_d;
    logic          drop;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_ni     (RSTn),
        .wr_en_i    (RX_Done_Sig),
        .wr_data_i  (RX_Data),
        .rd_en_i    (Rd_Req),
        .rd_data_o  (Rd_Data),
        .rd_valid_o (Rd_Valid),
        .level_o    (Level),
        .full_o     (Full),
        .empty_o    (Empty)
    );

    // Mirrors the FIFO's own write-acceptance rule: a byte is lost only when
    // full and no read frees a slot in the same cycle.
    assign drop = RX_Done_Sig && Full && !(Rd_Req && !Empty);

    // Receiver enable: only drop the enable between frames so a character
    // in flight is never cut off.
    always_comb begin
        state_d   = state_q;
        RX_En_Sig = 1'b1;
        unique case (state_q)
            ST_EN: begin
                if (Full && !Count_Sig) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                RX_En_Sig = 1'b0;
                if (!Full) begin
                    state_d = ST_EN;
                end
            end
            default: state_d = ST_EN;
        endcase
    end

    // New drop beats a simultaneous clear so no overflow event is lost.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (Clr_Ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Idle timer: fired_q keeps the timeout from repeating until another
    // byte arrives, even if the line goes busy and idle again meanwhile.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        fired_d    = fired_q;
        idle_to_d  = 1'b0;
        if (RX_Done_Sig) begin
            idle_cnt_d = '0;
            fired_d    = 1'b0;
        end else if (Count_Sig || Empty) begin
            idle_cnt_d = '0;
        end else if (BPS_CLK && !fired_q) begin
            if (idle_cnt_q == CW'(IDLE_BITS - 1)) begin
                idle_cnt_d = CW'(IDLE_BITS);
                fired_d    = 1'b1;
                idle_to_d  = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_EN;
            ovf_q      <= 1'b0;
            idle_cnt_q <= '0;
            fired_q    <= 1'b0;
            idle_to_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            idle_cnt_q <= idle_cnt_d;
            fired_q    <= fired_d;
            idle_to_q  <= idle_to_d;
        end
    end

    assign Overflow     = ovf_q;
    assign Idle_Timeout = idle_to_q;

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Self-checking bench for uart_rx_buffer_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_uart_rx_buffer_ctrl;

    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int IDLE_BITS = 20;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        BPS_CLK;
    logic        Count_Sig;
    logic        RX_Done_Sig;
    logic [7:0]  RX_Data;
    logic        RX_En_Sig;
    logic        Rd_Req;
    logic [7:0]  Rd_Data;
    logic        Rd_Valid;
    logic        Empty;
    logic        Full;
    logic [AW:0] Level;
    logic        Overflow;
    logic        Clr_Ovf;
    logic        Idle_Timeout;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_hold;
    bit         m_ovf;
    bit         m_fired;
    bit         m_to;
    bit         m_rv;
    int         m_cnt;
    logic [7:0] m_rd;

    int pulses;

    always #5 CLK = ~CLK;

    uart_rx_buffer_ctrl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .IDLE_BITS (IDLE_BITS)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .BPS_CLK      (BPS_CLK),
        .Count_Sig    (Count_Sig),
        .RX_Done_Sig  (RX_Done_Sig),
        .RX_Data      (RX_Data),
        .RX_En_Sig    (RX_En_Sig),
        .Rd_Req       (Rd_Req),
        .Rd_Data      (Rd_Data),
        .Rd_Valid     (Rd_Valid),
        .Empty        (Empty),
        .Full         (Full),
        .Level        (Level),
        .Overflow     (Overflow),
        .Clr_Ovf      (Clr_Ovf),
        .Idle_Timeout (Idle_Timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hold  = 1'b0;
        m_ovf   = 1'b0;
        m_fired = 1'b0;
        m_to    = 1'b0;
        m_rv    = 1'b0;
        m_cnt   = 0;
        m_rd    = 8'h00;
    endtask

    // One clock edge of the behavioural model, from the inputs currently driven.
    task automatic model_step();
        int sz;
        bit was_full;
        bit was_empty;
        bit racc;
        bit wacc;
        sz        = mq.size();
        was_full  = (sz == DEPTH);
        was_empty = (sz == 0);
        racc      = Rd_Req && !was_empty;
        wacc      = RX_Done_Sig && (!was_full || racc);
        m_rv      = racc;
        if (racc) m_rd = mq.pop_front();
        if (wacc) mq.push_back(RX_Data);
        if (RX_Done_Sig && !wacc) m_ovf = 1'b1;
        else if (Clr_Ovf)         m_ovf = 1'b0;
        // Receiver is held off only while the FIFO is full; entry waits for
        // the line to be quiet.
        if (!m_hold) m_hold = was_full && !Count_Sig;
        else         m_hold = was_full;
        m_to = 1'b0;
        if (RX_Done_Sig) begin
            m_cnt   = 0;
            m_fired = 1'b0;
        end else if (Count_Sig || was_empty) begin
            m_cnt = 0;
        end else if (BPS_CLK && !m_fired) begin
            m_cnt++;
            if (m_cnt == IDLE_BITS) begin
                m_fired = 1'b1;
                m_to    = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("rx_en",    RX_En_Sig,    !m_hold);
        check("rd_valid", Rd_Valid,     m_rv);
        check("rd_data",  Rd_Data,      m_rd);
        check("empty",    Empty,        mq.size() == 0);
        check("full",     Full,         mq.size() == DEPTH);
        check("level",    Level,        mq.size());
        check("overflow", Overflow,     m_ovf);
        check("idle_to",  Idle_Timeout, m_to);
    endtask

    // Inputs are set at the falling edge; the model advances with the rising
    // edge and outputs are compared at the following falling edge.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
        if (Idle_Timeout) pulses++;
    endtask

    task automatic clr_in();
        BPS_CLK     = 1'b0;
        Count_Sig   = 1'b0;
        RX_Done_Sig = 1'b0;
        RX_Data     = 8'h00;
        Rd_Req      = 1'b0;
        Clr_Ovf     = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        RX_Done_Sig = 1'b1;
        RX_Data     = b;
        cyc();
        RX_Done_Sig = 1'b0;
    endtask

    task automatic rd();
        Rd_Req = 1'b1;
        cyc();
        Rd_Req = 1'b0;
    endtask

    task automatic tick();
        BPS_CLK = 1'b1;
        cyc();
        BPS_CLK = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) rd();
        cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_en"},    RX_En_Sig,    1);
        check({tag, "_rd_data"},  Rd_Data,      0);
        check({tag, "_rd_valid"}, Rd_Valid,     0);
        check({tag, "_empty"},    Empty,        1);
        check({tag, "_full"},     Full,         0);
        check({tag, "_level"},    Level,        0);
        check({tag, "_overflow"}, Overflow,     0);
        check({tag, "_idle_to"},  Idle_Timeout, 0);
    endtask

    initial begin
        clr_in();
        RSTn = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_reset_vals("rst");
        RSTn = 1'b1;

        // 1: three bytes, no reads
        rx_byte(8'h55);
        rx_byte(8'hA3);
        rx_byte(8'h0F);
        check("t1_level", Level, 3);
        check("t1_empty", Empty, 0);
        check("t1_rx_en", RX_En_Sig, 1);

        // 2: read them back in order, then read while empty
        rd();
        check("t2_v0", Rd_Valid, 1);
        check("t2_d0", Rd_Data, 8'h55);
        rd();
        check("t2_d1", Rd_Data, 8'hA3);
        rd();
        check("t2_d2", Rd_Data, 8'h0F);
        rd();
        check("t2_v_empty", Rd_Valid, 0);
        check("t2_empty", Empty, 1);
        check("t2_hold_data", Rd_Data, 8'h0F);

        // 3: fill, hold off the receiver, overflow, clear, resume
        for (int i = 0; i < DEPTH; i++) rx_byte(8'h10 + 8'(i));
        check("t3_full", Full, 1);
        cyc();
        check("t3_rx_en_off", RX_En_Sig, 0);
        rx_byte(8'h99);
        check("t3_ovf", Overflow, 1);
        check("t3_level", Level, DEPTH);
        Clr_Ovf = 1'b1;
        cyc();
        Clr_Ovf = 1'b0;
        check("t3_ovf_clr", Overflow, 0);
        rd();
        check("t3_first", Rd_Data, 8'h10);
        cyc();
        check("t3_rx_en_on", RX_En_Sig, 1);
        for (int i = 1; i < DEPTH; i++) rd();
        check("t3_last", Rd_Data, 8'h17);
        cyc();

        // 4: full while a frame is in progress, then simultaneous rd/wr at full
        Count_Sig = 1'b1;
        for (int i = 0; i < DEPTH; i++) rx_byte(8'hC0 + 8'(i));
        cyc();
        cyc();
        check("t4_rx_en_busy", RX_En_Sig, 1);
        Count_Sig = 1'b0;
        cyc();
        check("t4_rx_en_off", RX_En_Sig, 0);
        Rd_Req = 1'b1;
        rx_byte(8'h7E);
        Rd_Req = 1'b0;
        check("t4_level", Level, DEPTH);
        check("t4_ovf", Overflow, 0);
        check("t4_rd", Rd_Data, 8'hC0);
        drain();

        // 5: idle timeout after one byte, then a busy line suppressing it
        rx_byte(8'h3C);
        pulses = 0;
        for (int i = 0; i < IDLE_BITS + 10; i++) tick();
        check("t5_one_pulse", pulses, 1);
        drain();
        rx_byte(8'h3D);
        pulses = 0;
        for (int i = 0; i < 10; i++) tick();
        Count_Sig = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("t5_no_pulse", pulses, 0);
        Count_Sig = 1'b0;
        drain();

        // 6: asynchronous reset with the FIFO full and the receiver held off
        for (int i = 0; i < DEPTH; i++) rx_byte(8'hA0 + 8'(i));
        cyc();
        check("t6_hold", RX_En_Sig, 0);
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        check_reset_vals("t6_rst");
        @(negedge CLK);
        RSTn = 1'b1;
        rx_byte(8'hE7);
        rd();
        check("t6_fresh", Rd_Data, 8'hE7);
        cyc();

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 200; i++) begin
                RX_Done_Sig = ($urandom_range(99) < 40);
                RX_Data     = 8'($urandom);
                Rd_Req      = ($urandom_range(99) < ((ph % 2 == 0) ? 15 : 55));
                BPS_CLK     = ($urandom_range(99) < 30);
                Clr_Ovf     = ($urandom_range(99) < 5);
                if ($urandom_range(99) < 10) Count_Sig = ~Count_Sig;
                cyc();
            end
        end
        clr_in();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
